instr_fetch_unit: RTL and testbench

//  Holds the program counter and fetches one instruction at a time from instruction memory.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory req/gnt/rvalid channel plus the
// valid/ready channel toward decode and the next-PC selection it returns.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fetch_err;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time
// and hands {instr, instr_pc} to decode. A misaligned next PC locks the unit
// in an error state until reset.
//
//  state  | meaning
//  BOOT   | one idle cycle after reset, then start first fetch
//  REQ    | imem_req high with imem_addr = pc, waiting for gnt
//  WAIT   | request accepted, waiting for rvalid
//  HOLD   | instr_valid high, waiting for decode to take it
//  ERR    | misaligned target seen, idle until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        imem_req_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fetch_err_q;
  logic [31:0] next_pc_d;

  // Candidate next PC, only meaningful on the decode handshake
  always_comb begin
    next_pc_d = bus.pc_src ? bus.pc_target : (instr_pc_q + 32'd4);
  end

  // Fetch sequencing; every output comes straight from a register here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          imem_req_q <= 1'b1;
          state_q    <= S_REQ;
        end
        S_REQ: begin
          // rvalid in this state is ignored, even alongside gnt
          if (bus.imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (next_pc_d[1:0] != 2'b00) begin
              fetch_err_q <= 1'b1;
              state_q     <= S_ERR;
            end else begin
              pc_q       <= next_pc_d;
              imem_req_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_ERR: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fetch_err_q   <= 1'b1;
        end
        default: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the main flow and
// hand-written sequences for stalls and reset during an outstanding fetch.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;
  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        src;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_0001, A2 = 32'h3333_0002;
  localparam logic [31:0] A3 = 32'h4444_0003, A4 = 32'h5555_0004, A5 = 32'h6666_0005;
  localparam logic [31:0] A6 = 32'h7777_0006, A7 = 32'h8888_0007, A8 = 32'h9999_0008;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF, GOOD = 32'hC0DE_0001;

  function automatic vec_t mk(logic r, logic g, logic rv, logic [31:0] rd, logic rdy,
                              logic s, logic [31:0] t, logic eq, logic [31:0] ea,
                              logic [31:0] ei, logic [31:0] ep, logic ev, logic ee);
    vec_t v;
    v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.src = s; v.tgt = t;
    v.e_req = eq; v.e_addr = ea; v.e_instr = ei; v.e_ipc = ep; v.e_valid = ev; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(logic r, logic g, logic rv, logic [31:0] rd, logic rdy, logic s,
                       logic [31:0] t);
    rst             = r;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
    bus.pc_src      = s;
    bus.pc_target   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic eq, logic [31:0] ea, logic [31:0] ei,
                         logic [31:0] ep, logic ev, logic ee);
    chk({tag, " imem_req"},    {31'h0, bus.imem_req},    {31'h0, eq});
    chk({tag, " imem_addr"},   bus.imem_addr,            ea);
    chk({tag, " instr"},       bus.instr,                ei);
    chk({tag, " instr_pc"},    bus.instr_pc,             ep);
    chk({tag, " instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, ev});
    chk({tag, " fetch_err"},   {31'h0, bus.fetch_err},   {31'h0, ee});
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    // reset, sequential fetches, stray rvalid in BOOT, ready outside HOLD
    vecs.push_back(mk(1,0,0,0,0,0,0,              0,32'h0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,BAD,0,0,0,            1,32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,1,32'h40,         0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,A0,0,0,0,             0,32'h0,A0,32'h0,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,              1,32'h4,A0,32'h0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'h4,A0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,A1,0,0,0,             0,32'h4,A1,32'h4,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,              1,32'h8,A1,32'h4,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'h8,A1,32'h4,0,0));
    vecs.push_back(mk(0,0,1,A2,0,0,0,             0,32'h8,A2,32'h8,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,              1,32'hC,A2,32'h8,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'hC,A2,32'h8,0,0));
    vecs.push_back(mk(0,0,1,A3,0,0,0,             0,32'hC,A3,32'hC,1,0));
    // branch to 0x100; gnt+rvalid together only acts on gnt
    vecs.push_back(mk(0,0,0,0,1,1,32'h100,        1,32'h100,A3,32'hC,0,0));
    vecs.push_back(mk(0,1,1,BAD,0,0,0,            0,32'h100,A3,32'hC,0,0));
    vecs.push_back(mk(0,0,1,A4,0,0,0,             0,32'h100,A4,32'h100,1,0));
    // jump to top of address space, then wrap to 0
    vecs.push_back(mk(0,0,0,0,1,1,32'hFFFF_FFFC,  1,32'hFFFF_FFFC,A4,32'h100,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'hFFFF_FFFC,A4,32'h100,0,0));
    vecs.push_back(mk(0,0,1,A5,0,0,0,             0,32'hFFFF_FFFC,A5,32'hFFFF_FFFC,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,32'h55,         1,32'h0,A5,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'h0,A5,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(0,0,1,A6,0,0,0,             0,32'h0,A6,32'h0,1,0));
    // misaligned target -> sticky error, pc untouched, everything ignored
    vecs.push_back(mk(0,0,0,0,1,1,32'h102,        0,32'h0,A6,32'h0,0,1));
    vecs.push_back(mk(0,1,1,BAD,1,0,0,            0,32'h0,A6,32'h0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,              0,32'h0,A6,32'h0,0,1));
    // reset clears error and refetches from RESET_PC
    vecs.push_back(mk(1,0,0,0,0,0,0,              0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,              1,32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,              0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,A7,0,0,0,             0,32'h0,A7,32'h0,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready,
            vecs[i].src, vecs[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
              vecs[i].e_ipc, vecs[i].e_valid, vecs[i].e_err);
    end

    // Stalls: from HOLD(pc 0, A7) handshake to 0x4, gnt withheld 3 cycles
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    chk_all("stall_hs", 1, 32'h4, A7, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      chk_all($sformatf("stall_gnt%0d", i), 1, 32'h4, A7, 32'h0, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    chk_all("stall_granted", 0, 32'h4, A7, 32'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, BAD, 0, 0, 0);
      step();
      chk_all($sformatf("stall_rv%0d", i), 0, 32'h4, A7, 32'h0, 0, 0);
    end
    drive(0, 0, 1, A8, 0, 0, 0);
    step();
    chk_all("stall_data", 0, 32'h4, A8, 32'h4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, BAD, 0, 1, 32'h200);
      step();
      chk_all($sformatf("stall_rdy%0d", i), 0, 32'h4, A8, 32'h4, 1, 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    chk_all("stall_next", 1, 32'h8, A8, 32'h4, 0, 0);

    // Reset while in WAIT, stray rvalid right after reset is dropped
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    chk_all("rstw_wait", 0, 32'h8, A8, 32'h4, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    chk_all("rstw_reset", 0, 32'h0, 0, 0, 0, 0);
    drive(0, 0, 1, BAD, 0, 0, 0);
    step();
    chk_all("rstw_stray", 1, 32'h0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    chk_all("rstw_gnt", 0, 32'h0, 0, 0, 0, 0);
    drive(0, 0, 1, GOOD, 0, 0, 0);
    step();
    chk_all("rstw_data", 0, 32'h0, GOOD, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
